// File: rtl/axilite_cmd_seq_if.sv
// Bundle between the command sequencer, its command/response client and the AXI4-Lite master user port.
interface axilite_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        write;
  logic        read;
  logic [31:0] user_waddr;
  logic [31:0] user_wdata;
  logic [31:0] user_raddr;
  logic        wr_ready;
  logic        rd_ready;
  logic        wr_error;
  logic        rd_error;
  logic [31:0] user_rdata;

  // cmd/rsp handshakes: a transfer happens on a rising edge with valid && ready; the
  // source keeps valid and payload stable until then. write/read and wr_ready/rd_ready are single-cycle pulses.
  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  wr_ready, rd_ready, wr_error, rd_error, user_rdata,
    output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err, rsp_timeout,
    output write, read, user_waddr, user_wdata, user_raddr
  );

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output wr_ready, rd_ready, wr_error, rd_error, user_rdata,
    input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err, rsp_timeout,
    input  write, read, user_waddr, user_wdata, user_raddr
  );
endinterface

// File: rtl/axilite_cmd_seq.sv
// Buffers single-beat commands and issues them one at a time to an AXI4-Lite master user port.
// Optional WAIT timeout is compiled in with AXILITE_CMD_SEQ_TIMEOUT_EN.
module axilite_cmd_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               m_axi_aclk,
  input  logic               m_axi_aresetn,
  axilite_cmd_seq_if.slave   bus,
  output logic               busy,
  output logic [1:0]         state_dbg
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("axilite_cmd_seq: illegal DEPTH or TIMEOUT");
  end

  cmd_t        mem [DEPTH];
  cmd_t        head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  state_t      state;
  logic        cur_we, expired;
  logic        write_q, read_q;
  logic [31:0] waddr_q, wdata_q, raddr_q;
  logic        rsp_valid_q, rsp_we_q, rsp_err_q, rsp_timeout_q;
  logic [31:0] rsp_rdata_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state == IDLE) && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge m_axi_aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

`ifdef AXILITE_CMD_SEQ_TIMEOUT_EN
  logic [15:0] tcnt, tcnt_nxt;
  // The compare uses the count including the current WAIT cycle, so WAIT lasts exactly TIMEOUT cycles.
  assign tcnt_nxt = tcnt + 16'd1;
  assign expired  = (tcnt_nxt == 16'(TIMEOUT));

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn)      tcnt <= '0;
    else if (state == ISSUE) tcnt <= '0;
    else if (state == WAIT)  tcnt <= tcnt_nxt;
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      cur_we        <= 1'b0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      raddr_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_we_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          cur_we  <= head.we;
          waddr_q <= head.we ? head.addr  : 32'd0;
          wdata_q <= head.we ? head.wdata : 32'd0;
          raddr_q <= head.we ? 32'd0      : head.addr;
          write_q <= head.we;
          read_q  <= !head.we;
          state   <= ISSUE;
        end
        ISSUE: begin
          write_q <= 1'b0;
          read_q  <= 1'b0;
          state   <= WAIT;
        end
        WAIT: if (cur_we ? bus.wr_ready : bus.rd_ready) begin
          rsp_valid_q   <= 1'b1;
          rsp_we_q      <= cur_we;
          rsp_rdata_q   <= cur_we ? 32'd0 : bus.user_rdata;
          rsp_err_q     <= cur_we ? bus.wr_error : bus.rd_error;
          rsp_timeout_q <= 1'b0;
          state         <= RESP;
        end else if (expired) begin
          rsp_valid_q   <= 1'b1;
          rsp_we_q      <= cur_we;
          rsp_rdata_q   <= 32'd0;
          rsp_err_q     <= 1'b1;
          rsp_timeout_q <= 1'b1;
          state         <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.write       = write_q;
  assign bus.read        = read_q;
  assign bus.user_waddr  = waddr_q;
  assign bus.user_wdata  = wdata_q;
  assign bus.user_raddr  = raddr_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_we      = rsp_we_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign busy            = (state != IDLE) || !empty;
  assign state_dbg       = state;
endmodule

// File: tb/tb_axilite_cmd_seq.sv
// Bench for axilite_cmd_seq: directed commands, a memory-backed master responder and an in-order scoreboard.
module tb_axilite_cmd_seq;
  localparam int DEPTH = 4;
`ifdef AXILITE_CMD_SEQ_TIMEOUT_EN
  localparam int TIMEOUT = 10;
`else
  localparam int TIMEOUT = 255;
`endif
  localparam int RW = 35;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  axilite_cmd_seq_if bus ();

  axilite_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .bus           (bus),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int accepted = 0, answered = 0, cyc = 0;
  int accept_cyc = 0, pulse_cyc = 0, cpl_cyc = 0, rise_cyc = 0;
  cmd_t issue_q[$];
  logic [RW-1:0] exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem [logic [31:0]];
  logic [RW-1:0] last_rsp = '0;
  logic [RW-1:0] prev_act = '0;
  logic [95:0] held_ops = '0;
  logic inflight_v = 1'b0, inflight_we = 1'b0;
  logic prev_pulse = 1'b0, prev_rspv = 1'b0, prev_rspr = 1'b0;
  bit   resp_en = 1'b1, junk_en = 1'b0, late_pulse_req = 1'b0;
  int   resp_lat = 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin : compare
    cmd_t          c;
    logic [RW-1:0] e, act;
    logic [95:0]   ops;
    cyc++;
    ops = {bus.user_waddr, bus.user_wdata, bus.user_raddr};
    act = {bus.rsp_we, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout};
    if (!rst_n) begin
      issue_q.delete();
      exp_q.delete();
      accepted = 0; answered = 0;
      inflight_v = 1'b0; held_ops = '0;
      prev_pulse = 1'b0; prev_rspv = 1'b0; prev_rspr = 1'b0;
      check("reset_outputs", {bus.cmd_ready, busy, bus.rsp_valid, bus.write, bus.read, act, ops},
            {1'b1, 135'd0});
    end else begin
      check("busy", busy, accepted != answered);
      if (bus.write || bus.read) begin
        check("pulse_has_cmd", issue_q.size() != 0, 1'b1);
        check("pulse_spacing", {prev_pulse, bus.rsp_valid, inflight_v}, 3'b000);
        if (issue_q.size() != 0) begin
          c = issue_q.pop_front();
          check("pulse_kind", {bus.write, bus.read}, {c.we, !c.we});
          held_ops = c.we ? {c.addr, c.wdata, 32'd0} : {64'd0, c.addr};
          check("pulse_ops", ops, held_ops);
          if (!resp_en)
            e = {c.we, 32'd0, 1'b1, 1'b1};
          else if (c.we) begin
            e = {1'b1, 32'd0, c.addr >= 32'h200, 1'b0};
            ref_mem[c.addr] = c.wdata;
          end else
            e = {1'b0, ref_mem.exists(c.addr) ? ref_mem[c.addr] : ~c.addr, c.addr >= 32'h200, 1'b0};
          exp_q.push_back(e);
          inflight_v  = 1'b1;
          inflight_we = c.we;
          pulse_cyc   = cyc;
        end
      end else begin
        check("ops_hold", ops, held_ops);
      end
      if (inflight_v && !bus.rsp_valid && (inflight_we ? bus.wr_ready : bus.rd_ready)) cpl_cyc = cyc;
      if (prev_rspv && !prev_rspr) check("rsp_hold", {bus.rsp_valid, act}, {1'b1, prev_act});
      if (prev_rspv && prev_rspr)  check("rsp_drop", bus.rsp_valid, 1'b0);
      if (bus.rsp_valid && !prev_rspv) begin
        rise_cyc = cyc;
        check("rsp_has_cmd", exp_q.size() != 0, 1'b1);
        if (resp_en) check("cpl_to_rsp", rise_cyc - cpl_cyc, 1);
        else         check("timeout_lat", rise_cyc - pulse_cyc, TIMEOUT + 1);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_fields", act, e);
        end
        last_rsp = act;
        answered++;
        n_rsp++;
        inflight_v = 1'b0;
      end
      check("cmd_ready", bus.cmd_ready, issue_q.size() < DEPTH);
      if (bus.cmd_valid && bus.cmd_ready) begin
        issue_q.push_back({bus.cmd_we, bus.cmd_addr, bus.cmd_wdata});
        accepted++;
        accept_cyc = cyc;
      end
      prev_pulse = bus.write || bus.read;
      prev_rspv  = bus.rsp_valid;
      prev_rspr  = bus.rsp_ready;
      prev_act   = act;
    end
  end

  // ---------------- master responder ----------------
  task automatic idle_master();
    bus.wr_ready = 1'b0; bus.rd_ready = 1'b0;
    bus.wr_error = 1'b0; bus.rd_error = 1'b0;
    bus.user_rdata = 32'h5A5A_5A5A;
  endtask

  initial begin : responder
    logic        we;
    logic [31:0] a, wd;
    bit          ok;
    idle_master();
    forever begin
      @(posedge clk); #1;
      if (late_pulse_req) begin
        bus.rd_ready = 1'b1; bus.rd_error = 1'b1; bus.user_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        idle_master();
        late_pulse_req = 1'b0;
      end else if (rst_n && resp_en && (bus.write || bus.read)) begin
        we = bus.write;
        a  = we ? bus.user_waddr : bus.user_raddr;
        wd = bus.user_wdata;
        ok = 1'b1;
        for (int i = 0; i < resp_lat; i++) begin
          @(posedge clk); #1;
          if (!rst_n) begin ok = 1'b0; break; end
        end
        if (ok && junk_en) begin
          if (we) begin bus.rd_ready = 1'b1; bus.rd_error = 1'b1; bus.user_rdata = 32'hBAD0_BAD0; end
          else    begin bus.wr_ready = 1'b1; bus.wr_error = 1'b1; end
          @(posedge clk); #1;
          idle_master();
          ok = rst_n;
        end
        if (ok) begin
          if (we) begin
            bus.wr_ready = 1'b1; bus.wr_error = (a >= 32'h200); mem[a] = wd;
          end else begin
            bus.rd_ready = 1'b1; bus.rd_error = (a >= 32'h200);
            bus.user_rdata = mem.exists(a) ? mem[a] : ~a;
          end
          @(posedge clk); #1;
          idle_master();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int   t;
    logic acc;
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = addr; bus.cmd_wdata = data;
    t = 0; acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk); acc = bus.cmd_ready;
      @(posedge clk); #1;
      t++;
    end
    check("push_in_budget", acc, 1'b1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int t;
    t = 0;
    while (n_rsp < target && t < budget) begin @(posedge clk); #1; t++; end
    check("rsp_in_budget", n_rsp >= target, 1'b1);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int target;
    target = n_rsp + 1;
    push(we, addr, data);
    wait_rsp(target, 100);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int base, target, saved;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    xact(1'b1, 32'h5, 32'hA5A5_0001);
    check("wr5_issue_lat", pulse_cyc - accept_cyc, 2);
    check("wr5_waddr", bus.user_waddr, 32'h5);
    check("wr5_rsp", last_rsp, {1'b1, 32'd0, 1'b0, 1'b0});
    cycles(2);
    xact(1'b0, 32'h5, 32'h0);
    check("rd5_ops", {bus.user_waddr, bus.user_raddr}, {32'd0, 32'h5});
    check("rd5_rsp", last_rsp, {1'b0, 32'hA5A5_0001, 1'b0, 1'b0});

    xact(1'b1, 32'h200, 32'hDEAD_0200);
    check("wr200_err_rsp", last_rsp, {1'b1, 32'd0, 1'b1, 1'b0});
    xact(1'b0, 32'h200, 32'h0);
    check("rd200_err_rsp", last_rsp, {1'b0, 32'hDEAD_0200, 1'b1, 1'b0});

    junk_en = 1'b1;
    xact(1'b1, 32'h40, 32'h1234_5678);
    check("wr40_mismatch_rsp", last_rsp, {1'b1, 32'd0, 1'b0, 1'b0});
    xact(1'b0, 32'h40, 32'h0);
    check("rd40_mismatch_rsp", last_rsp, {1'b0, 32'h1234_5678, 1'b0, 1'b0});
    junk_en = 1'b0;

    resp_lat = 4;
    xact(1'b0, 32'h77, 32'h0);
    check("rd77_slow_rsp", last_rsp, {1'b0, 32'hFFFF_FF88, 1'b0, 1'b0});
    resp_lat = 1;
    cycles(2);

    // Backpressure: response held, FIFO fills behind the stalled command.
    base = accepted;
    target = n_rsp + 6;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(i[0], 32'h100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    check("bp_accepts", accepted - base, 5);
    @(negedge clk);
    check("bp_full", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    fork
      push(1'b1, 32'h114, 32'hC0DE_0005);
      begin
        cycles(5);
        check("bp_still_blocked", accepted - base, 5);
        bus.rsp_ready = 1'b1;
      end
    join
    wait_rsp(target, 300);
    check("bp_last_rsp", last_rsp, {1'b1, 32'd0, 1'b0, 1'b0});
    cycles(2);

`ifdef AXILITE_CMD_SEQ_TIMEOUT_EN
    resp_en = 1'b0;
    xact(1'b0, 32'h300, 32'h0);
    resp_en = 1'b1;
    check("to_rsp", last_rsp, {1'b0, 32'd0, 1'b1, 1'b1});
    late_pulse_req = 1'b1;
    cycles(3);
    xact(1'b1, 32'h44, 32'h4444);
    check("after_to_rsp", last_rsp, {1'b1, 32'd0, 1'b0, 1'b0});
    cycles(2);
`endif

    // Asynchronous reset while a read sits in WAIT with two more commands queued.
    resp_lat = 30;
    saved = n_rsp;
    push(1'b0, 32'h500, 32'h0);
    push(1'b1, 32'h504, 32'h1);
    push(1'b1, 32'h508, 32'h2);
    cycles(2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs",
          {bus.cmd_ready, busy, bus.rsp_valid, bus.write, bus.read, bus.rsp_we, bus.rsp_rdata,
           bus.rsp_err, bus.rsp_timeout, bus.user_waddr, bus.user_wdata, bus.user_raddr},
          {1'b1, 135'd0});
    check("async_rst_state", state_dbg, 2'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    resp_lat = 1;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
    cycles(5);
    check("post_rst_no_rsp", n_rsp, saved);
    xact(1'b0, 32'h5, 32'h0);
    check("post_rst_rd5_rsp", last_rsp, {1'b0, 32'hA5A5_0001, 1'b0, 1'b0});
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axilite_cmd_seq.md
# axilite_cmd_seq

Command sequencer that sits directly upstream of the AXI4-Lite master's user port. It buffers single-beat read/write commands in a small FIFO and issues each one as a one-cycle `write`/`read` pulse. It waits for the master's `wr_ready`/`rd_ready` completion pulse, with an optional timeout, and returns one response (read data, error, timeout) per command over a valid/ready handshake.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255: WAIT-state cycle limit; 1..65535; used only when the timeout feature is compiled in.

Ports:
- `m_axi_aclk`  in  1  clock; all logic on rising edge.
- `m_axi_aresetn`  in  1  one clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  target address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_we`  out  1  echo of command type.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_err`  out  1  master reported error, or timeout.
- `rsp_timeout`  out  1  completion not seen within `TIMEOUT`.
- `write`  out  1  one-cycle write request to the master.
- `read`  out  1  one-cycle read request to the master.
- `user_waddr`, `user_wdata`, `user_raddr`  out  32 each  request operands.
- `wr_ready`, `rd_ready`  in  1 each  master completion pulses.
- `wr_error`, `rd_error`  in  1 each  valid only together with the matching ready.
- `user_rdata`  in  32  valid only with `rd_ready`.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- FIFO: `DEPTH` entries of {we, addr, wdata}; registered read (no fall-through).
  - `cmd_ready` = !full.
  - Push when `cmd_valid && cmd_ready`.
  - When full, no push is accepted, even if a pop occurs in the same cycle.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop the head, load operands, go to ISSUE. Otherwise stay.
  - ISSUE: drive `write` (we=1) or `read` (we=0) high for this one cycle only. Clear the timeout counter. Go to WAIT.
  - WAIT, write command: on `wr_ready`, capture `wr_error` into `rsp_err` and set `rsp_rdata`=0.
  - WAIT, read command: on `rd_ready`, capture `user_rdata` and `rd_error`.
  - WAIT, on capture: set `rsp_valid`, go to RESP.
  - WAIT, mismatched ready (e.g. `rd_ready` during a write): ignored.
  - RESP: hold all `rsp_*` stable until `rsp_ready`. Then clear `rsp_valid` and go to IDLE.
- Only one command is outstanding. A new command is never issued while a response is unconsumed.
- IDLE always occupies at least one cycle between commands, so the master has returned to its idle state.
- `user_waddr`, `user_wdata`, `user_raddr` stay stable from ISSUE until the next pop. The unused operand is driven 0.
- Completion pulses arriving in IDLE, ISSUE or RESP are dropped.

## Timing
- Reset values: every output 0, except `cmd_ready`=1. FIFO empty, FSM in IDLE, counter 0.
- Reset mid-operation aborts the command in flight and empties the FIFO. No response is produced.
- Command pushed at cycle 0 into an empty FIFO with an idle FSM:
  - pop in cycle 1 (IDLE);
  - `write`/`read` high in cycle 2 only;
  - WAIT from cycle 3.
- Completion sampled in cycle N → `rsp_valid` high from cycle N+1.
- With `rsp_ready` held at 1: `rsp_valid` is high for exactly one cycle, then the FSM is in IDLE.
- Minimum issue spacing is 4 cycles (IDLE, ISSUE, WAIT, RESP) plus the master's latency.
- Simultaneous push and pop on a non-full FIFO: count is unchanged.

## Configuration
- `AXILITE_CMD_SEQ_TIMEOUT_EN` defined:
  - a 16-bit counter increments each WAIT cycle;
  - when the counter equals `TIMEOUT` with no completion in that cycle: respond with `rsp_timeout`=1, `rsp_err`=1, `rsp_rdata`=0, and go to RESP;
  - a completion in the same cycle wins.
- Not defined: the counter is absent, WAIT waits indefinitely, and `rsp_timeout` is tied to 0.

## Test plan
- Write, then read back:
  - write addr 0x5, data 0xA5A5_0001: one-cycle `write` in cycle 2 with `user_waddr`=5; after `wr_ready`, response we=1, err=0.
  - read addr 0x5, with `user_rdata`=0xA5A5_0001 on `rd_ready`: `rsp_rdata`=0xA5A5_0001, err=0.
- Error path: write addr 0x200 with the master returning `wr_error`=1 → `rsp_err`=1, `rsp_timeout`=0. Read with `rd_error`=1 → `rsp_err`=1, `rsp_rdata` equals the sampled data.
- FIFO full and backpressure:
  - hold `rsp_ready`=0 and push 6 commands (DEPTH=4): `cmd_ready` drops after the 5th accept (4 in FIFO plus 1 in flight);
  - release `rsp_ready`: responses emerge in push order, with no `write`/`read` pulse while `rsp_valid`=1.
- Timeout, macro defined, TIMEOUT=10: issue a read, never pulse `rd_ready` → `rsp_valid` 11 cycles after ISSUE with `rsp_timeout`=1, `rsp_err`=1. A late `rd_ready` is ignored and the next command proceeds normally.
- Reset mid-WAIT: deassert `m_axi_aresetn` asynchronously mid-cycle → all outputs 0 immediately and `cmd_ready`=1. After release, the FIFO is empty and `busy`=0.
